// File: rtl/single_macc_interpolator_if.sv
// Sample/coefficient bus for single_macc_interpolator; the slave modport faces the interpolator and
// the master modport faces the source/consumer side.
interface single_macc_interpolator_if;
  logic               CoeffClk_i;
  logic [3:0]         CoeffAddr_i;
  logic signed [17:0] CoeffData_i;
  logic               CoeffWr_i;
  logic signed [17:0] Data_i;
  logic               DataNd_i;
  logic signed [17:0] Data_o;
  logic               DataValid_o;

  modport master (
    output CoeffClk_i, CoeffAddr_i, CoeffData_i, CoeffWr_i, Data_i, DataNd_i,
    input  Data_o, DataValid_o
  );

  modport slave (
    input  CoeffClk_i, CoeffAddr_i, CoeffData_i, CoeffWr_i, Data_i, DataNd_i,
    output Data_o, DataValid_o
  );
endinterface

// File: rtl/single_macc_interpolator.sv
// Polyphase FIR interpolator by InterpolationK sharing one MAC over 16 coefficients.
// Optional SMI_ROUND_EN: round half up before the output shift instead of truncating.
module single_macc_interpolator #(
  parameter int unsigned InterpolationK = 2
) (
  input logic                        Clk_i,
  input logic                        Rst_i,
  single_macc_interpolator_if.slave  bus
);

  localparam int unsigned Taps = 16 / InterpolationK;

  logic signed [17:0] coef [16];
  logic signed [17:0] delay_q [Taps];

  logic               busy_q;
  logic [3:0]         cnt_q;
  logic               accept;

  logic [3:0]         issueAddr;
  logic signed [17:0] issueSamp;
  logic               issueFirst;
  logic               issueLast;

  logic               s1Valid_q, s1First_q, s1Last_q;
  logic signed [17:0] s1Coef_q, s1Samp_q;
  logic               s2Valid_q, s2First_q, s2Last_q;
  logic signed [35:0] prod_q;
  logic signed [39:0] acc_q;
  logic               accDone_q;
  logic signed [17:0] data_q;
  logic               dataValid_q;

  logic unusedCoeffClk;
  assign unusedCoeffClk = bus.CoeffClk_i;

  function automatic logic signed [17:0] sat18(input logic signed [39:0] a);
    logic signed [40:0] r;
    logic signed [40:0] sh;
`ifdef SMI_ROUND_EN
    r = 41'(a) + 41'sd65536;
`else
    r = 41'(a);
`endif
    sh = r >>> 17;
    if (sh > 41'sd131071) begin
      return 18'sd131071;
    end else if (sh < -41'sd131072) begin
      return -18'sd131072;
    end else begin
      return $signed(sh[17:0]);
    end
  endfunction

  // A new sample may also land on the last issue cycle so inputs can stream every 16 cycles.
  assign accept = bus.DataNd_i && (!busy_q || (cnt_q == 4'd15));

  // Issue order is phase-major: cnt = phase * Taps + tap, reading coef[tap * K + phase].
  always_comb begin
    int unsigned cntInt;
    int unsigned phase;
    int unsigned tap;
    cntInt     = 32'(cnt_q);
    phase      = cntInt / Taps;
    tap        = cntInt % Taps;
    issueAddr  = 4'(tap * InterpolationK + phase);
    issueFirst = (tap == 0);
    issueLast  = (tap == Taps - 1);
    issueSamp  = '0;
    for (int unsigned i = 0; i < Taps; i++) begin
      if (tap == i) begin
        issueSamp = delay_q[i];
      end
    end
  end

  // Coefficient RAM has no reset.
  always_ff @(posedge Clk_i) begin
    if (bus.CoeffWr_i) begin
      coef[bus.CoeffAddr_i] <= bus.CoeffData_i;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int i = 0; i < int'(Taps); i++) begin
        delay_q[i] <= '0;
      end
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      s1Valid_q   <= 1'b0;
      s1First_q   <= 1'b0;
      s1Last_q    <= 1'b0;
      s1Coef_q    <= '0;
      s1Samp_q    <= '0;
      s2Valid_q   <= 1'b0;
      s2First_q   <= 1'b0;
      s2Last_q    <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      accDone_q   <= 1'b0;
      data_q      <= '0;
      dataValid_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = int'(Taps) - 1; i > 0; i--) begin
          delay_q[i] <= delay_q[i-1];
        end
        delay_q[0] <= bus.Data_i;
        busy_q     <= 1'b1;
        cnt_q      <= '0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          busy_q <= 1'b0;
        end
      end

      s1Valid_q <= busy_q;
      s1First_q <= issueFirst;
      s1Last_q  <= issueLast;
      s1Coef_q  <= coef[issueAddr];
      s1Samp_q  <= issueSamp;

      s2Valid_q <= s1Valid_q;
      s2First_q <= s1First_q;
      s2Last_q  <= s1Last_q;
      prod_q    <= s1Coef_q * s1Samp_q;

      if (s2Valid_q) begin
        acc_q <= s2First_q ? 40'(prod_q) : acc_q + 40'(prod_q);
      end
      accDone_q <= s2Valid_q && s2Last_q;

      // acc_q may already be reloaded by the next phase on this edge; the old value is sampled.
      dataValid_q <= accDone_q;
      if (accDone_q) begin
        data_q <= sat18(acc_q);
      end
    end
  end

  assign bus.Data_o      = data_q;
  assign bus.DataValid_o = dataValid_q;

endmodule

// File: tb/tb_single_macc_interpolator.sv
// Scoreboard bench for single_macc_interpolator (K = 2): a reference FIR model pushes expected
// outputs at each accepted input; a monitor queues observed pulses; each test compares them.
module tb_single_macc_interpolator;
  localparam int unsigned K = 2;
  localparam int unsigned T = 16 / K;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  single_macc_interpolator_if bus();

  single_macc_interpolator #(.InterpolationK(K)) dut (
    .Clk_i (Clk),
    .Rst_i (Rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int obsData[$];
  int obsCyc[$];
  int expQ[$];
  logic signed [17:0] mCoef [16];
  logic signed [17:0] mDelay [T];

  always @(negedge Clk) begin
    if (bus.DataValid_o === 1'b1) begin
      obsData.push_back(int'(bus.Data_o));
      obsCyc.push_back(cyc);
    end
  end

  function automatic int model_out(int p);
    longint acc = 0;
    for (int j = 0; j < int'(T); j++) acc += longint'(mDelay[j]) * longint'(mCoef[j*K+p]);
`ifdef SMI_ROUND_EN
    acc += 65536;
`endif
    acc = acc >>> 17;
    if (acc > 131071) acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  function automatic void model_accept(int x);
    for (int j = int'(T) - 1; j > 0; j--) mDelay[j] = mDelay[j-1];
    mDelay[0] = 18'(x);
    for (int p = 0; p < int'(K); p++) expQ.push_back(model_out(p));
  endfunction

  function automatic void clear_all();
    obsData.delete(); obsCyc.delete(); expQ.delete();
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic write_coef(int a, int v);
    bus.CoeffWr_i = 1'b1; bus.CoeffAddr_i = 4'(a); bus.CoeffData_i = 18'(v);
    mCoef[a] = 18'(v);
    @(negedge Clk);
    bus.CoeffWr_i = 1'b0;
  endtask

  task automatic send(int x, output int acceptCyc);
    bus.DataNd_i = 1'b1; bus.Data_i = 18'(x);
    acceptCyc = cyc + 1;
    model_accept(x);
    @(negedge Clk);
    bus.DataNd_i = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    for (int j = 0; j < int'(T); j++) mDelay[j] = '0;
    clear_all();
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (bus.DataValid_o !== 1'b0 || bus.Data_o !== 18'sd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b data=%0d required 0/0", bus.DataValid_o, bus.Data_o);
    end
    Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (bus.DataValid_o !== 1'b0 || bus.Data_o !== 18'sd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: valid=%b data=%0d required 0/0", i, bus.DataValid_o,
                 bus.Data_o);
      end
    end
    checks++;
    if (obsData.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pulses: got %0d pulses required 0", obsData.size());
    end
  endtask

  task automatic test_impulse();
    int a0, tmp, got;
    for (int i = 0; i < 16; i++) write_coef(i, 4096 * (i + 1));
    tick(4);
    clear_all();
    send(32768, a0);
    tick(15);
    for (int i = 0; i < 7; i++) begin
      send(0, tmp);
      tick(15);
    end
    tick(40);
    checks++;
    if (obsData.size() != 16) begin
      errors++;
      $display("FAIL impulse_count: got %0d pulses required 16", obsData.size());
    end
    if (obsCyc.size() >= 2) begin
      checks++;
      if (obsCyc[0] - a0 != int'(T) + 3 || obsCyc[1] - a0 != 2 * int'(T) + 3) begin
        errors++;
        $display("FAIL impulse_latency: got %0d,%0d required %0d,%0d", obsCyc[0] - a0,
                 obsCyc[1] - a0, T + 3, 2 * T + 3);
      end
    end
    for (int n = 0; n < 16 && obsData.size() > 0; n++) begin
      got = obsData.pop_front();
      checks++;
      if (got != 1024 * (n + 1)) begin
        errors++;
        $display("FAIL impulse_value[%0d]: got %0d required %0d", n, got, 1024 * (n + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int tmp, got, want, n;
    for (int i = 0; i < 16; i++) write_coef(i, $urandom_range(80000) - 40000);
    tick(4);
    clear_all();
    for (int i = 0; i < 6; i++) begin
      send($urandom_range(200000) - 100000, tmp);
      tick(15);
    end
    tick(40);
    checks++;
    if (obsData.size() != 6 * int'(K)) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses required %0d", obsData.size(), 6 * K);
    end
    for (int i = 1; i < obsCyc.size(); i++) begin
      checks++;
      if (obsCyc[i] - obsCyc[i-1] != int'(T)) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, obsCyc[i] - obsCyc[i-1], T);
      end
    end
    n = 0;
    while (obsData.size() > 0 && expQ.size() > 0) begin
      got = obsData.pop_front();
      want = expQ.pop_front();
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL b2b_value[%0d]: got %0d required %0d", n, got, want);
      end
      n++;
    end
  endtask

  task automatic test_dc_gain();
    int tmp, got, want, last;
    for (int i = 0; i < 16; i++) write_coef(i, 16384);
    tick(4);
    clear_all();
    for (int i = 0; i < 16; i++) begin
      send(65536, tmp);
      tick(15);
    end
    tick(40);
    checks++;
    if (obsData.size() != 32) begin
      errors++;
      $display("FAIL dc_count: got %0d pulses required 32", obsData.size());
    end
    last = 0;
    for (int n = 0; obsData.size() > 0 && expQ.size() > 0; n++) begin
      got = obsData.pop_front();
      want = expQ.pop_front();
      last = got;
      checks++;
      if (got != want || (n >= 16 && got != 65536)) begin
        errors++;
        $display("FAIL dc_value[%0d]: got %0d required %0d", n, got, want);
      end
    end
    checks++;
    if (bus.Data_o !== 18'sd65536 || last != 65536) begin
      errors++;
      $display("FAIL dc_hold: got %0d (last pulse %0d) required 65536", bus.Data_o, last);
    end
  endtask

  task automatic test_dropped();
    int a, got, want;
    clear_all();
    send(1000, a);
    tick(7);
    bus.DataNd_i = 1'b1; bus.Data_i = 18'sd5000;
    tick(1);
    bus.DataNd_i = 1'b0;
    tick(40);
    checks++;
    if (obsData.size() != int'(K)) begin
      errors++;
      $display("FAIL dropped_count: got %0d pulses required %0d", obsData.size(), K);
    end
    while (obsData.size() > 0 && expQ.size() > 0) begin
      got = obsData.pop_front();
      want = expQ.pop_front();
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL dropped_value: got %0d required %0d", got, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    int got, want;
    clear_all();
    bus.CoeffWr_i = 1'b1; bus.CoeffAddr_i = 4'd0; bus.CoeffData_i = -18'sd50000;
    mCoef[0] = -18'sd50000;
    bus.DataNd_i = 1'b1; bus.Data_i = 18'sd30000;
    model_accept(30000);
    tick(1);
    bus.CoeffWr_i = 1'b0; bus.DataNd_i = 1'b0;
    tick(40);
    checks++;
    if (obsData.size() != int'(K)) begin
      errors++;
      $display("FAIL simul_count: got %0d pulses required %0d", obsData.size(), K);
    end
    while (obsData.size() > 0 && expQ.size() > 0) begin
      got = obsData.pop_front();
      want = expQ.pop_front();
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL simul_value: got %0d required %0d", got, want);
      end
    end
  endtask

  task automatic test_saturation();
    int tmp, got, want;
    for (int i = 0; i < 16; i++) write_coef(i, 131071);
    tick(4);
    clear_all();
    for (int i = 0; i < 16; i++) begin
      send(i < 8 ? 131071 : -131072, tmp);
      tick(15);
    end
    tick(40);
    checks++;
    if (obsData.size() != 32) begin
      errors++;
      $display("FAIL sat_count: got %0d pulses required 32", obsData.size());
    end else begin
      checks++;
      if (obsData[15] != 131071 || obsData[31] != -131072) begin
        errors++;
        $display("FAIL sat_limits: got %0d,%0d required 131071,-131072", obsData[15],
                 obsData[31]);
      end
    end
    for (int n = 0; obsData.size() > 0 && expQ.size() > 0; n++) begin
      got = obsData.pop_front();
      want = expQ.pop_front();
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL sat_value[%0d]: got %0d required %0d", n, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    for (int i = 0; i < 16; i++) write_coef(i, 4096 * (i + 1));
    tick(4);
    clear_all();
    send(100000, a);
    tick(4);
    do_reset();
    tick(40);
    checks++;
    if (obsData.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d pulses required 0", obsData.size());
    end
    test_impulse();
  endtask

  initial begin
    bus.CoeffClk_i = 1'b0; bus.CoeffAddr_i = '0; bus.CoeffData_i = '0; bus.CoeffWr_i = 1'b0;
    bus.Data_i = '0; bus.DataNd_i = 1'b0;
    for (int i = 0; i < 16; i++) mCoef[i] = '0;
    for (int j = 0; j < int'(T); j++) mDelay[j] = '0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_dc_gain();
    test_dropped();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
